mem_arbiter: RTL

Shares one single-ported synchronous instruction/data memory between the CPU's instruction-fetch stage and its load/store stage. Each access is a req/ack handshake. The block serialises accesses through a small FSM that counts the memory's fixed latency, and gives data accesses priority. It also exposes a stall signal that the pipeline control uses to freeze the PC and the pipeline registers.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_select.sv | 57 +++++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types and constants for the instruction/data memory
// arbiter.
//   state_t     : arbiter FSM states
//   GNT_IF/GNT_D: grant encoding (which requester owns the current slot)
//   MEM_LAT_DEF : default memory read latency in cycles
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_D  = 1'b1;

   localparam int MEM_LAT_DEF = 2;

endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select -- grant choice between fetch and data requesters.
// Data normally wins. With MEM_ARB_STARVE_GUARD_EN defined, a skip counter
// tracks data grants made while fetch was waiting and hands the slot to fetch
// once MAX_SKIP such grants have been made in a row.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (counter only)
//   if_req    : fetch request
//   d_req     : data request
//   grant_en  : arbiter is in IDLE; a grant is taken this edge if any req
//   gnt       : chosen requester (GNT_IF / GNT_D), combinational
// Macro: MEM_ARB_STARVE_GUARD_EN enables the skip counter.
module mem_arb_select
   import mem_arb_pkg::*;
#(
   parameter int MAX_SKIP = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic if_req,
   input  logic d_req,
   input  logic grant_en,
   output logic gnt
);

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int SKIP_W = $clog2(MAX_SKIP + 1);

   logic [SKIP_W-1:0] skip_cnt;
   logic              fetch_due;

   assign fetch_due = if_req && (skip_cnt == SKIP_W'(MAX_SKIP));

   always_comb begin
      gnt = GNT_IF;
      if (d_req && !fetch_due)
         gnt = GNT_D;
   end

   // Counter only moves on an edge where a grant is actually taken.
   always_ff @(posedge clk) begin
      if (rst)
         skip_cnt <= '0;
      else if (grant_en && (if_req || d_req)) begin
         if (gnt == GNT_IF)
            skip_cnt <= '0;
         else if (if_req)
            skip_cnt <= skip_cnt + 1'b1;
      end
   end
`else
   logic unused_sel;

   assign gnt        = d_req ? GNT_D : GNT_IF;
   assign unused_sel = ^{clk, rst, grant_en, 32'(MAX_SKIP)};
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one single-ported synchronous memory between the
// instruction-fetch and load/store stages. One access at a time runs through
// IDLE -> ISSUE -> (WAIT) -> RESP; data accesses have priority.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   if_req/if_addr                : fetch request (held until if_ack)
//   if_rdata/if_ack               : fetched word, one-cycle completion
//   d_req/d_we/d_addr/d_wdata     : data request (held until d_ack)
//   d_rdata/d_ack                 : load data, one-cycle completion
//   mem_en/mem_we/mem_addr/mem_wdata : memory strobe and command
//   mem_rdata                     : memory read data, MEM_LAT cycles after
//                                   the request is granted
//   stall                         : a request is outstanding without its ack
// Macro: MEM_ARB_STARVE_GUARD_EN (in mem_arb_select) bounds fetch starvation.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MEM_LAT  = MEM_LAT_DEF,
   parameter int MAX_SKIP = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);

   state_t           state, state_nxt;
   logic             gnt_sel, gnt_q;
   logic [CNT_W-1:0] lat_cnt;
   logic             any_req;
   logic             capture;

   assign any_req = if_req | d_req;
   assign stall   = (if_req & ~if_ack) | (d_req & ~d_ack);

   // Read data is sampled MEM_LAT edges after the grant edge: straight out of
   // ISSUE for single-cycle memory, otherwise on the WAIT edge where the
   // counter (loaded with MEM_LAT-1) steps from 1 to 0.
   assign capture = ((state == ISSUE) && (MEM_LAT == 1)) ||
                    ((state == WAIT) && (lat_cnt == CNT_W'(1)));

   mem_arb_select #(
      .MAX_SKIP (MAX_SKIP)
   ) u_select (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .d_req    (d_req),
      .grant_en (state == IDLE),
      .gnt      (gnt_sel)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ISSUE;
         ISSUE:   state_nxt = (MEM_LAT == 1) ? RESP : WAIT;
         WAIT:    if (capture) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_q     <= GNT_IF;
         lat_cnt   <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_ack    <= 1'b0;
         d_ack     <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         mem_en <= 1'b0;
         if_ack <= 1'b0;
         d_ack  <= 1'b0;

         case (state)
            IDLE: begin
               if (any_req) begin
                  // Latch the winner's command; later input changes are ignored.
                  gnt_q  <= gnt_sel;
                  mem_en <= 1'b1;
                  if (gnt_sel == GNT_D) begin
                     mem_we    <= d_we;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                  end else begin
                     mem_we   <= 1'b0;
                     mem_addr <= if_addr;
                  end
               end
            end
            ISSUE:   lat_cnt <= CNT_W'(MEM_LAT - 1);
            WAIT:    lat_cnt <= lat_cnt - 1'b1;
            default: ;
         endcase

         if (capture) begin
            if (gnt_q == GNT_D) begin
               d_ack <= 1'b1;
               if (!mem_we)
                  d_rdata <= mem_rdata;
            end else begin
               if_ack   <= 1'b1;
               if_rdata <= mem_rdata;
            end
         end
      end
   end

endmodule
